uart_tx_arbiter: RTL and testbench

- Shares a single 8N1 UART transmit line between two byte-stream requesters, e.g. a CPU console and a hardware status/logger source.
- Sits between the requesters and the board uart_txd pin.
- Arbitration is frame-based round-robin, with an optional message lock so multi-byte messages are never interleaved.
- Contains the baud-rate sequencer that drives the serializer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_serializer.sv | 116 +++++++++++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// State encoding, line levels and counter widths.
`timescale 1ns/1ps
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   BIT_CNT_W       = 3;
    localparam int   BAUD_CNT_W      = 16;

    function automatic logic [1:0] owner_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, 8 data bits LSB first, 1 or 2 stop bits.
// A 16-bit down-counter reloaded at each bit boundary times every bit.
`timescale 1ns/1ps
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_txd
);

    localparam logic [BAUD_CNT_W-1:0] BIT_RELOAD = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT   = '1;
    localparam bit                    TWO_STOP   = (STOP_BITS == 2);

    uart_state_t             state_q, state_d;
    logic [BAUD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]              shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic                    stop_q, stop_d;
    logic                    txd_q, txd_d;
    logic                    tick;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        txd_d   = txd_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_START;
                    cnt_d   = BIT_RELOAD;
                    shift_d = i_byte;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    cnt_d   = BIT_RELOAD;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        txd_d   = UART_IDLE_LEVEL;
                        stop_d  = 1'b0;
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    // Second stop bit simply re-arms the counter once
                    if (TWO_STOP && !stop_q) begin
                        stop_d = 1'b1;
                        cnt_d  = BIT_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            txd_q   <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_txd  = txd_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART TX arbiter: frame round-robin with message lock.
// Accepts one byte per idle cycle and hands it to the serializer.
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid0,
    input  logic [7:0] i_data0,
    input  logic       i_last0,
    output logic       o_ready0,
    input  logic       i_valid1,
    input  logic [7:0] i_data1,
    input  logic       i_last1,
    output logic       o_ready1,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_uart_txd
);

    logic       ser_busy;
    logic       ser_txd;
    logic       lock_q, lock_d;
    logic       rr_q, rr_d;
    logic [1:0] grant_q, grant_d;
    logic       acc0, acc1, acc;
    logic       sel;
    logic       sel_last;
    logic [7:0] sel_data;

    // While locked, grant_q names the owner and the other side is ignored
    always_comb begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (i_rst_n && !ser_busy) begin
            if (lock_q) begin
                acc0 = grant_q[0] && i_valid0;
                acc1 = grant_q[1] && i_valid1;
            end else if (i_valid0 && i_valid1) begin
                acc0 = !rr_q;
                acc1 = rr_q;
            end else begin
                acc0 = i_valid0;
                acc1 = i_valid1;
            end
        end
    end

    assign acc      = acc0 | acc1;
    assign sel      = acc1;
    assign sel_data = acc1 ? i_data1 : i_data0;
    assign sel_last = acc1 ? i_last1 : i_last0;

    always_comb begin
        lock_d  = lock_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        if (acc) begin
            grant_d = owner_onehot(sel);
            lock_d  = !sel_last;
            if (sel_last) begin
                rr_d = !sel;
            end
        end else if (!ser_busy && !lock_q) begin
            grant_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q  <= 1'b0;
            rr_q    <= 1'b0;
            grant_q <= '0;
        end else begin
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (acc),
        .i_byte  (sel_data),
        .o_busy  (ser_busy),
        .o_txd   (ser_txd)
    );

    assign o_ready0   = acc0;
    assign o_ready1   = acc1;
    assign o_grant    = grant_q;
    assign o_busy     = ser_busy;
    assign o_uart_txd = ser_txd;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter at 4 clocks per bit, 1 stop bit.
// A line receiver pops expected bytes as frames appear on txd.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       l0 = 1'b0, l1 = 1'b0;
    logic       r0, r1;
    logic [1:0] grant;
    logic       busy;
    logic       txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n0 = 0, n1 = 0;
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid0   (v0),
        .i_data0    (d0),
        .i_last0    (l0),
        .o_ready0   (r0),
        .i_valid1   (v1),
        .i_data1    (d1),
        .i_last1    (l1),
        .o_ready1   (r1),
        .o_grant    (grant),
        .o_busy     (busy),
        .o_uart_txd (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Line receiver: samples mid-bit; frames cut by reset are discarded
    initial begin : mon
        logic       prev;
        logic [7:0] got;
        logic       ab;
        logic       sb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !txd) begin
                ab = 1'b0;
                got = '0;
                repeat (2) @(negedge clk);
                if (!rst_n) ab = 1'b1;
                sb = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    got[i] = txd;
                end
                repeat (4) @(negedge clk);
                if (!rst_n) ab = 1'b1;
                if (!ab) begin
                    chk("start_bit", int'(sb), 0);
                    chk("stop_bit", int'(txd), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %02h required none", got);
                    end else begin
                        chk("frame_data", int'(got), int'(exp_q.pop_front()));
                    end
                end
            end
            prev = txd;
        end
    end

    initial begin : ready_width
        int w0;
        int w1;
        w0 = 0;
        w1 = 0;
        forever begin
            @(negedge clk);
            #2;
            if (r0) begin
                if (w0 == 0) n0++;
                w0++;
            end else if (w0 != 0) begin
                chk("ready0_width", w0, 1);
                w0 = 0;
            end
            if (r1) begin
                if (w1 == 0) n1++;
                w1++;
            end else if (w1 != 0) begin
                chk("ready1_width", w1, 1);
                w1 = 0;
            end
        end
    end

    task automatic send(input int p, input logic [7:0] d, input logic l,
                        input bit keep, output int acc);
        int n;
        @(negedge clk);
        if (p == 0) begin
            v0 = 1'b1; d0 = d; l0 = l;
        end else begin
            v1 = 1'b1; d1 = d; l1 = l;
        end
        #1;
        n = 0;
        while (!(p == 0 ? r0 : r1) && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("accept_in_time_p%0d", p), int'(n < 4000), 1);
        acc = cyc;
        @(negedge clk);
        if (!keep) begin
            if (p == 0) v0 = 1'b0;
            else v1 = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", int'(n < 5000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a0, a1, s, bad;
        repeat (3) @(negedge clk);
        chk("rst_txd", int'(txd), 1);
        chk("rst_ready0", int'(r0), 0);
        chk("rst_ready1", int'(r1), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin from reset pointer: 0 wins first
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h0B);
        fork
            send(0, 8'hA0, 1'b1, 1'b0, a0);
            send(1, 8'h0B, 1'b1, 1'b0, a1);
        join
        chk("rr_accept_spacing", a1 - a0, 41);
        wait_done();

        // Lock: 0 sends a 3-byte message while 1 waits
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h41);
        s = n1;
        fork
            begin
                send(0, 8'h31, 1'b0, 1'b0, a0);
                send(0, 8'h32, 1'b0, 1'b0, a0);
                send(0, 8'h33, 1'b1, 1'b0, a0);
                chk("lock_no_ready1", n1 - s, 0);
            end
            send(1, 8'h41, 1'b1, 1'b0, a1);
        join
        wait_done();

        // Starvation hold while the locked owner pauses
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        fork
            begin
                send(0, 8'h10, 1'b0, 1'b0, a0);
                repeat (44) @(negedge clk);
                chk("starve_grant", int'(grant), 1);
                bad = 0;
                repeat (200) begin
                    @(negedge clk);
                    #2;
                    if (grant != 2'b01 || r1 || !txd || busy) bad++;
                end
                chk("starve_hold", bad, 0);
                send(0, 8'h11, 1'b1, 1'b0, a0);
            end
            begin
                repeat (3) @(negedge clk);
                send(1, 8'h22, 1'b1, 1'b0, a1);
            end
        join
        wait_done();

        // Single byte with timing
        exp_q.push_back(8'h55);
        send(0, 8'h55, 1'b1, 1'b0, a0);
        chk("single_txd_start", int'(txd), 0);
        chk("single_busy_rise", int'(busy), 1);
        chk("single_grant", int'(grant), 1);
        repeat (39) @(negedge clk);
        chk("single_busy_last", int'(busy), 1);
        @(negedge clk);
        chk("single_busy_fall", int'(busy), 0);
        @(negedge clk);
        chk("single_grant_clear", int'(grant), 0);
        wait_done();

        // Held valid for three frames, data changed after each ready
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h63);
        s = n0;
        send(0, 8'h61, 1'b1, 1'b1, a0);
        send(0, 8'h62, 1'b1, 1'b1, a0);
        send(0, 8'h63, 1'b1, 1'b0, a0);
        wait_done();
        chk("ready0_pulses", n0 - s, 3);

        // Async reset during data bit 3 of 0xFF
        send(0, 8'hFF, 1'b1, 1'b0, a0);
        repeat (17) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_txd", int'(txd), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_grant", int'(grant), 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        exp_q.push_back(8'h00);
        send(0, 8'h00, 1'b1, 1'b0, a0);
        chk("post_rst_txd_start", int'(txd), 0);
        chk("post_rst_busy", int'(busy), 1);
        wait_done();

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
